// File: rtl/rf_wport_arb_if.sv
// Write-port arbiter bus: pipeline write-back request, long-latency result
// handshake, register-file write port and hazard-side status outputs.
interface rf_wport_arb_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Pipeline write-back stage
  logic          p_valid;
  logic [4:0]    p_reg;
  logic [31:0]   p_data;
  logic          p_stall;

  // Long-latency unit results
  logic          m_valid;
  logic          m_ready;
  logic [4:0]    m_reg;
  logic [31:0]   m_data;

  // Register-file write port
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;

  // Hazard-unit visibility
  logic [31:0]   pend_mask;
  logic [CW-1:0] fifo_cnt;

  // Master side: pipeline and long-latency unit drive requests, observe grants.
  modport master (
    output p_valid, p_reg, p_data, m_valid, m_reg, m_data,
    input  p_stall, m_ready, rf_we, rf_waddr, rf_wdata, pend_mask, fifo_cnt
  );

  // Slave side: the arbiter.
  modport slave (
    input  p_valid, p_reg, p_data, m_valid, m_reg, m_data,
    output p_stall, m_ready, rf_we, rf_waddr, rf_wdata, pend_mask, fifo_cnt
  );
endinterface

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter. Pipeline write-backs win the port; long-
// latency results queue in an in-order FIFO and drain into idle cycles. A
// starvation counter forces a one-cycle drain by stalling the pipeline.
module rf_wport_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic           arb_clk,
  input logic           arb_rst_n,
  rf_wport_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    ST_NORMAL,
    ST_FORCE
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       mem_reg_q  [DEPTH];
  logic [31:0]      mem_data_q [DEPTH];

  logic             empty, full, push, pop, we;
  logic [31:0]      pend;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // Accept only when not full; a result for r0 completes the handshake but is dropped.
  assign bus.m_ready  = arb_rst_n & ~full;
  assign push         = bus.m_valid & bus.m_ready & (bus.m_reg != 5'd0);
  assign bus.fifo_cnt = cnt_q;
  assign bus.rf_we    = we & arb_rst_n;

  // Arbitration FSM: grant selection, starvation tracking and write-port mux.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d      = state_q;
    starve_d     = starve_q;
    pop          = 1'b0;
    we           = 1'b0;
    bus.p_stall  = 1'b0;
    bus.rf_waddr = bus.p_reg;
    bus.rf_wdata = bus.p_data;
    unique case (state_q)
      ST_NORMAL: begin
        if (bus.p_valid) begin
          we = (bus.p_reg != 5'd0);
          if (!empty) begin
            starve_d = starve_q + 1'b1;
            // Head stays queued (no pop this cycle), so the limit forces a drain.
            if (starve_q == SW'(STARVE_MAX - 1)) state_d = ST_FORCE;
          end else begin
            starve_d = '0;
          end
        end else if (!empty) begin
          pop          = 1'b1;
          we           = 1'b1;
          bus.rf_waddr = mem_reg_q[rd_ptr_q];
          bus.rf_wdata = mem_data_q[rd_ptr_q];
          starve_d     = '0;
        end else begin
          starve_d = '0;
        end
      end
      ST_FORCE: begin
        // Only entered with a non-empty FIFO; pipeline is held off for one cycle.
        bus.p_stall  = 1'b1;
        pop          = 1'b1;
        we           = 1'b1;
        bus.rf_waddr = mem_reg_q[rd_ptr_q];
        bus.rf_wdata = mem_data_q[rd_ptr_q];
        starve_d     = '0;
        state_d      = ST_NORMAL;
      end
    endcase
  end

  // FIFO bookkeeping: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    vld_d    = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end

  // Pending-write mask built from registered entries only.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend[mem_reg_q[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign bus.pend_mask = pend;

  // Control state registers; async reset discards all queued entries.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state_q  <= ST_NORMAL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      vld_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      vld_q    <= vld_d;
    end
  end

  // FIFO storage written at the tail on each accepted push.
  always_ff @(posedge arb_clk) begin
    // NOTE: storage has no reset; vld_q/cnt_q gate every read, so stale contents are never used.
    if (push) begin
      mem_reg_q[wr_ptr_q]  <= bus.m_reg;
      mem_data_q[wr_ptr_q] <= bus.m_data;
    end
  end
endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb (DEPTH=4, STARVE_MAX=3): per-cycle vectors
// with hand-computed expectations plus an async-reset sequence.
module tb_rf_wport_arb;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rf_wport_arb_if #(.DEPTH(4)) bus ();

  rf_wport_arb #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .arb_clk   (clk),
    .arb_rst_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  pr;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        st;
    logic        mrdy;
    logic [2:0]  cnt;
    logic [31:0] pend;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check outputs before the next edge.
  task automatic run(input string tag, input vec_t v);
    bus.p_valid = v.pv;
    bus.p_reg   = v.pr;
    bus.p_data  = v.pd;
    bus.m_valid = v.mv;
    bus.m_reg   = v.mr;
    bus.m_data  = v.md;
    #3;
    check({tag, ".rf_we"}, {31'd0, bus.rf_we}, {31'd0, v.we});
    if (v.we) begin
      check({tag, ".rf_waddr"}, {27'd0, bus.rf_waddr}, {27'd0, v.wa});
      check({tag, ".rf_wdata"}, bus.rf_wdata, v.wd);
    end
    check({tag, ".p_stall"},   {31'd0, bus.p_stall}, {31'd0, v.st});
    check({tag, ".m_ready"},   {31'd0, bus.m_ready}, {31'd0, v.mrdy});
    check({tag, ".fifo_cnt"},  {29'd0, bus.fifo_cnt}, {29'd0, v.cnt});
    check({tag, ".pend_mask"}, bus.pend_mask, v.pend);
    @(posedge clk);
    #1;
  endtask

  // Hazard protocol: the pipeline must never write a register still queued.
  always @(negedge clk) begin
    if (rst_n && bus.p_valid && bus.p_reg != 5'd0)
      check("proto_pend_hazard", {31'd0, bus.pend_mask[bus.p_reg]}, 32'd0);
  end

  vec_t vecs [15];
  vec_t fullv [11];
  vec_t rstv [3];

  initial begin
    // Single drain, same-cycle conflict, starvation, zero register.
    vecs[0]  = '{0, 0, 0,          1, 5, 32'h11, 0, 0, 0,          0, 1, 0, 32'h0};
    vecs[1]  = '{0, 0, 0,          0, 0, 0,     1, 5, 32'h11,      0, 1, 1, 32'h20};
    vecs[2]  = '{0, 0, 0,          0, 0, 0,     0, 0, 0,           0, 1, 0, 32'h0};
    vecs[3]  = '{0, 0, 0,          1, 7, 32'h77, 0, 0, 0,          0, 1, 0, 32'h0};
    vecs[4]  = '{1, 3, 32'hAA,     0, 0, 0,     1, 3, 32'hAA,      0, 1, 1, 32'h80};
    vecs[5]  = '{0, 0, 0,          0, 0, 0,     1, 7, 32'h77,      0, 1, 1, 32'h80};
    vecs[6]  = '{0, 0, 0,          0, 0, 0,     0, 0, 0,           0, 1, 0, 32'h0};
    vecs[7]  = '{1, 1, 32'h101,    1, 9, 32'h99, 1, 1, 32'h101,    0, 1, 0, 32'h0};
    vecs[8]  = '{1, 1, 32'h102,    0, 0, 0,     1, 1, 32'h102,     0, 1, 1, 32'h200};
    vecs[9]  = '{1, 1, 32'h103,    0, 0, 0,     1, 1, 32'h103,     0, 1, 1, 32'h200};
    vecs[10] = '{1, 1, 32'h104,    0, 0, 0,     1, 1, 32'h104,     0, 1, 1, 32'h200};
    vecs[11] = '{1, 1, 32'h105,    0, 0, 0,     1, 9, 32'h99,      1, 1, 1, 32'h200};
    vecs[12] = '{1, 1, 32'h105,    0, 0, 0,     1, 1, 32'h105,     0, 1, 0, 32'h0};
    vecs[13] = '{1, 0, 32'h33,     1, 0, 32'h5, 0, 0, 0,           0, 1, 0, 32'h0};
    vecs[14] = '{0, 0, 0,          0, 0, 0,     0, 0, 0,           0, 1, 0, 32'h0};

    // Fill to full under continuous pipeline traffic, forced drain, refused pushes, drain order.
    fullv[0]  = '{1, 2, 32'h200, 1, 10, 32'hA0, 1, 2, 32'h200,  0, 1, 0, 32'h0};
    fullv[1]  = '{1, 2, 32'h201, 1, 11, 32'hA1, 1, 2, 32'h201,  0, 1, 1, 32'h400};
    fullv[2]  = '{1, 2, 32'h202, 1, 12, 32'hA2, 1, 2, 32'h202,  0, 1, 2, 32'hC00};
    fullv[3]  = '{1, 2, 32'h203, 1, 13, 32'hA3, 1, 2, 32'h203,  0, 1, 3, 32'h1C00};
    fullv[4]  = '{1, 2, 32'h204, 1, 14, 32'hA4, 1, 10, 32'hA0,  1, 0, 4, 32'h3C00};
    fullv[5]  = '{1, 2, 32'h204, 1, 14, 32'hA4, 1, 2, 32'h204,  0, 1, 3, 32'h3800};
    fullv[6]  = '{0, 0, 0,       1, 15, 32'hA5, 1, 11, 32'hA1,  0, 0, 4, 32'h7800};
    fullv[7]  = '{0, 0, 0,       0, 0, 0,       1, 12, 32'hA2,  0, 1, 3, 32'h7000};
    fullv[8]  = '{0, 0, 0,       0, 0, 0,       1, 13, 32'hA3,  0, 1, 2, 32'h6000};
    fullv[9]  = '{0, 0, 0,       0, 0, 0,       1, 14, 32'hA4,  0, 1, 1, 32'h4000};
    fullv[10] = '{0, 0, 0,       0, 0, 0,       0, 0, 0,        0, 1, 0, 32'h0};

    // Queue three entries while the pipeline holds the port.
    rstv[0] = '{1, 4, 32'h400, 1, 20, 32'hB0, 1, 4, 32'h400, 0, 1, 0, 32'h0};
    rstv[1] = '{1, 4, 32'h401, 1, 21, 32'hB1, 1, 4, 32'h401, 0, 1, 1, 32'h100000};
    rstv[2] = '{1, 4, 32'h402, 1, 22, 32'hB2, 1, 4, 32'h402, 0, 1, 2, 32'h300000};

    bus.p_valid = 1'b0;
    bus.p_reg   = '0;
    bus.p_data  = '0;
    bus.m_valid = 1'b0;
    bus.m_reg   = '0;
    bus.m_data  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset.fifo_cnt",  {29'd0, bus.fifo_cnt}, 32'd0);
    check("reset.pend_mask", bus.pend_mask, 32'd0);
    check("reset.rf_we",     {31'd0, bus.rf_we}, 32'd0);
    check("reset.p_stall",   {31'd0, bus.p_stall}, 32'd0);
    check("reset.m_ready",   {31'd0, bus.m_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("reset.m_ready_rise", {31'd0, bus.m_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) run($sformatf("basic[%0d]", i), vecs[i]);
    for (int i = 0; i < 11; i++) run($sformatf("full[%0d]", i), fullv[i]);
    for (int i = 0; i < 3; i++)  run($sformatf("rstq[%0d]", i), rstv[i]);

    // Three entries queued; pulse reset before the next edge.
    bus.p_valid = 1'b0;
    bus.m_valid = 1'b0;
    #1;
    check("rstq.pre_cnt",  {29'd0, bus.fifo_cnt}, 32'd3);
    check("rstq.pre_pend", bus.pend_mask, 32'h700000);
    #1 rst_n = 1'b0;
    #1;
    check("rstq.cnt",     {29'd0, bus.fifo_cnt}, 32'd0);
    check("rstq.pend",    bus.pend_mask, 32'd0);
    check("rstq.rf_we",   {31'd0, bus.rf_we}, 32'd0);
    check("rstq.m_ready", {31'd0, bus.m_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rstq.m_ready_rise", {31'd0, bus.m_ready}, 32'd1);
    @(posedge clk);
    #1;
    // None of the discarded entries may ever reach the write port.
    for (int i = 0; i < 4; i++) run($sformatf("post_rst[%0d]", i), vecs[14]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
